// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I/RV64I decode constants.
//   - OPC_*  : major opcode values (instr[6:0])
//   - fmt_t  : instruction format tag presented on out_fmt
//   - F7_*   : funct7 values distinguishing base, alternate (SUB/SRA) and M-extension ops
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/inst_decode_stage_imm_gen.sv
// imm_gen: combinational RISC-V immediate assembly.
//   instr : 32-bit instruction word
//   fmt   : decoded format tag (FMT_NONE and FMT_R yield zero)
//   imm   : immediate sign-extended from instr[31] to XLEN bits
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    input  fmt_t             fmt,
    output logic [XLEN-1:0]  imm
);

    // Reassemble the scattered immediate bits for each format.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
            FMT_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
            FMT_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            FMT_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: registered RV32I/RV64I decode stage with a DEPTH-entry
// decoded-instruction buffer between fetch and execute.
//   clk, reset (async, active-high), flush (sync discard of buffered entries)
//   in_valid/in_ready/in_instr/in_pc     : fetch side handshake
//   out_valid/out_ready                  : execute side handshake
//   out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
//   out_imm, out_fmt, out_illegal        : head entry of the buffer
// Build option: define RV_M_EXT_EN to accept OP encodings with funct7=0000001
// (MUL/DIV/REM) as legal R-type; otherwise they are flagged illegal.
// funct3/funct7 carry the raw instruction bits for every legal entry; unused
// register indices are zeroed, and illegal entries carry only their pc.
module inst_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    // RV64 shift amounts are 6 bits, so instr[25] belongs to shamt there.
    localparam logic [6:0] SHIFT_F7_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        fmt_t            fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]       opc_s;
    logic [2:0]       f3_s;
    logic [6:0]       f7_s;
    fmt_t             fmt_s;
    logic             legal_s;
    logic [XLEN-1:0]  imm_s;
    entry_t           dec_s;
    logic             push_s;
    logic             pop_s;

    entry_t           stor_q [DEPTH];
    entry_t           stor_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign opc_s = in_instr[6:0];
    assign f3_s  = in_instr[14:12];
    assign f7_s  = in_instr[31:25];

    // Classify the opcode into a format and decide legality.
    always_comb begin
        fmt_s   = FMT_NONE;
        legal_s = 1'b0;
        case (opc_s)
            OPC_LUI, OPC_AUIPC: begin
                fmt_s   = FMT_U;
                legal_s = 1'b1;
            end
            OPC_JAL: begin
                fmt_s   = FMT_J;
                legal_s = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt_s   = FMT_I;
                legal_s = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt_s = FMT_I;
                if (f3_s == 3'b001) begin
                    legal_s = ((f7_s & SHIFT_F7_MASK) == F7_BASE);
                end else if (f3_s == 3'b101) begin
                    legal_s = ((f7_s & SHIFT_F7_MASK) == F7_BASE) ||
                              ((f7_s & SHIFT_F7_MASK) == F7_ALT);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_BRANCH: begin
                fmt_s   = FMT_B;
                legal_s = 1'b1;
            end
            OPC_STORE: begin
                fmt_s   = FMT_S;
                legal_s = 1'b1;
            end
            OPC_OP: begin
                fmt_s = FMT_R;
                case (f7_s)
                    F7_BASE: legal_s = 1'b1;
                    F7_ALT:  legal_s = (f3_s == 3'b000) || (f3_s == 3'b101);
                    F7_MULDIV: begin
`ifdef RV_M_EXT_EN
                        legal_s = 1'b1;
`else
                        legal_s = 1'b0;
`endif
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            default: begin
                fmt_s   = FMT_NONE;
                legal_s = 1'b0;
            end
        endcase
        // Compressed / non-32-bit encodings are never accepted here.
        if (in_instr[1:0] != 2'b11) begin
            legal_s = 1'b0;
        end else begin
            legal_s = legal_s;
        end
        if (!legal_s) begin
            fmt_s = FMT_NONE;
        end else begin
            fmt_s = fmt_s;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt_s),
        .imm   (imm_s)
    );

    // Build the decoded entry, zeroing register indices the format lacks.
    always_comb begin
        dec_s         = '0;
        dec_s.pc      = in_pc;
        dec_s.fmt     = fmt_s;
        dec_s.illegal = !legal_s;
        if (legal_s) begin
            dec_s.imm    = imm_s;
            dec_s.opcode = opc_s;
            dec_s.funct3 = f3_s;
            dec_s.funct7 = f7_s;
            dec_s.rd     = ((fmt_s == FMT_S) || (fmt_s == FMT_B)) ? 5'd0 : in_instr[11:7];
            dec_s.rs1    = ((fmt_s == FMT_U) || (fmt_s == FMT_J)) ? 5'd0 : in_instr[19:15];
            dec_s.rs2    = ((fmt_s == FMT_I) || (fmt_s == FMT_U) || (fmt_s == FMT_J)) ?
                           5'd0 : in_instr[24:20];
        end else begin
            dec_s.imm = '0;
        end
    end

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Next-state for buffer storage, pointers and occupancy; flush wins.
    always_comb begin
        stor_d   = stor_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                stor_d[wr_ptr_q] = dec_s;
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers; reset clears storage so outputs read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stor_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            stor_q   <= stor_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_pc      = stor_q[rd_ptr_q].pc;
    assign out_imm     = stor_q[rd_ptr_q].imm;
    assign out_opcode  = stor_q[rd_ptr_q].opcode;
    assign out_funct3  = stor_q[rd_ptr_q].funct3;
    assign out_funct7  = stor_q[rd_ptr_q].funct7;
    assign out_rs1     = stor_q[rd_ptr_q].rs1;
    assign out_rs2     = stor_q[rd_ptr_q].rs2;
    assign out_rd      = stor_q[rd_ptr_q].rd;
    assign out_fmt     = stor_q[rd_ptr_q].fmt;
    assign out_illegal = stor_q[rd_ptr_q].illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage (XLEN=32, DEPTH=2): directed
// vectors followed by random traffic against a queue-based reference model.
module tb_inst_decode_stage;

    localparam int DEPTH = 2;
`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3, out_fmt;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_illegal;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t mq[$];

    inst_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return {out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2,
                out_rd, out_imm, out_fmt, out_illegal};
    endfunction

    // Reference decode straight from the ISA tables, immediates by arithmetic.
    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc);
        exp_t        e;
        int          fmt, imm, sgn;
        bit          ok;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
        e = '0; e.pc = pc; fmt = 7; ok = 1'b0;
        if (w[1:0] == 2'b11) begin
            case (opc)
                7'h37, 7'h17:                     fmt = 4;
                7'h6F:                            fmt = 5;
                7'h67, 7'h03, 7'h0F, 7'h73, 7'h13: fmt = 1;
                7'h63:                            fmt = 3;
                7'h23:                            fmt = 2;
                7'h33:                            fmt = 0;
                default:                          fmt = 7;
            endcase
            ok = (fmt != 7);
            if (opc == 7'h13 && f3 == 3'b001) ok = (f7 == 7'h00);
            if (opc == 7'h13 && f3 == 3'b101) ok = (f7 == 7'h00) || (f7 == 7'h20);
            if (opc == 7'h33)
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (f7 == 7'h01 && M_EN);
        end
        if (!ok) begin
            e.fmt = 3'd7; e.ill = 1'b1;
            return e;
        end
        sgn = w[31] ? 1 : 0;
        e.fmt = fmt[2:0]; e.opc = opc; e.f3 = f3; e.f7 = f7;
        e.rd  = (fmt == 2 || fmt == 3) ? 5'd0 : w[11:7];
        e.rs1 = (fmt == 4 || fmt == 5) ? 5'd0 : w[19:15];
        e.rs2 = (fmt == 1 || fmt == 4 || fmt == 5) ? 5'd0 : w[24:20];
        case (fmt)
            1: imm = -2048 * sgn + int'(w[30:20]);
            2: imm = -2048 * sgn + int'(w[30:25]) * 32 + int'(w[11:7]);
            3: imm = -4096 * sgn + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            4: imm = int'(w & 32'hFFFFF000);
            5: imm = -1048576 * sgn + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default: imm = 0;
        endcase
        e.imm = imm;
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model is updated and the DUT compared after the edge.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic rdy, input logic fl, output bit pushed);
        bit   do_push, do_pop;
        exp_t e;
        in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = (mq.size() != 0) && rdy;
        e = ref_decode(w, pc);
        @(posedge clk);
        #1;
        pushed = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                pushed = 1'b1;
            end
        end
        check("in_ready", 128'(in_ready), 128'(mq.size() != DEPTH));
        check("out_valid", 128'(out_valid), 128'(mq.size() != 0));
        if (mq.size() != 0) check("head", 128'(observed()), 128'(mq[0]));
    endtask

    initial begin
        bit          acc;
        logic [31:0] w;
        logic [6:0]  opcs [12];
        logic [6:0]  f7s [4];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
        f7s  = '{7'h00, 7'h20, 7'h01, 7'h55};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
        in_pc = 32'h0; out_ready = 1'b0;
        #12;
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_ready", 128'(in_ready), 128'(1));
        check("reset_fields", 128'(observed()), 128'(0));
        reset = 1'b0;

        // Spec vectors, each popped the cycle after it is pushed.
        step(1'b1, 32'h002081B3, 32'h0000_1000, 1'b1, 1'b0, acc);
        check("add_fields", 128'({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7}),
              128'({7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0}));
        check("add_fmt_imm", 128'({out_fmt, out_imm, out_illegal}), 128'({3'd0, 32'd0, 1'b0}));
        step(1'b1, 32'hFFF00293, 32'h0000_1004, 1'b1, 1'b0, acc);
        check("addi", 128'({out_fmt, out_rd, out_rs2, out_imm}), 128'({3'd1, 5'd5, 5'd0, 32'hFFFFFFFF}));
        step(1'b1, 32'h0020A423, 32'h0000_1008, 1'b1, 1'b0, acc);
        check("sw", 128'({out_fmt, out_rd, out_imm}), 128'({3'd2, 5'd0, 32'd8}));
        step(1'b1, 32'hFE000EE3, 32'h0000_100C, 1'b1, 1'b0, acc);
        check("beq", 128'({out_fmt, out_rd, out_imm}), 128'({3'd3, 5'd0, 32'hFFFFFFFC}));
        step(1'b1, 32'h023100B3, 32'h0000_1010, 1'b1, 1'b0, acc);
        if (M_EN) check("mul_m", 128'({out_illegal, out_fmt}), 128'({1'b0, 3'd0}));
        else      check("mul_nom", 128'({out_illegal, out_fmt}), 128'({1'b1, 3'd7}));
        step(1'b1, 32'h00000000, 32'h0000_1014, 1'b1, 1'b0, acc);
        check("zero_word", 128'({out_illegal, out_fmt, out_pc}), 128'({1'b1, 3'd7, 32'h0000_1014}));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Back-pressure: third word must be held until a slot frees.
        step(1'b1, 32'h00100093, 32'h0000_2000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00200113, 32'h0000_2004, 1'b0, 1'b0, acc);
        check("full_ready", 128'(in_ready), 128'(0));
        step(1'b1, 32'h00300193, 32'h0000_2008, 1'b0, 1'b0, acc);
        check("held_head_pc", 128'(out_pc), 128'(32'h0000_2000));
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1'b1, 32'h00300193, 32'h0000_2008, 1'b1, 1'b0, acc);
        check("third_accepted", 128'(acc), 128'(1));
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Flush with two buffered entries and a concurrent offer.
        step(1'b1, 32'h00400213, 32'h0000_3000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00500293, 32'h0000_3004, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00600313, 32'h0000_3008, 1'b0, 1'b1, acc);
        check("flush_valid", 128'(out_valid), 128'(0));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                w[6:0] = opcs[$urandom_range(0, 11)];
                if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[31:25] = f7s[$urandom_range(0, 3)];
            end
            step(1'($urandom_range(0, 1)), w, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), acc);
        end

        // Asynchronous reset in the middle of a cycle with data buffered.
        step(1'b1, 32'h00700393, 32'h0000_4000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00800413, 32'h0000_4004, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_valid", 128'(out_valid), 128'(0));
        check("async_ready", 128'(in_ready), 128'(1));
        check("async_fields", 128'(observed()), 128'(0));
        #2 reset = 1'b0;
        mq.delete();
        step(1'b1, 32'h00900493, 32'h0000_5000, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered RV32I instruction-decode stage with a valid/ready handshake on both sides. Every base-ISA format (R/I/S/B/U/J) is split into fields with a sign-extended immediate, format tag and illegal-instruction flag. Decoded results are held in a small FIFO so fetch and execute can stall independently. It sits between instruction fetch and register-file read/execute.

## Interface
- XLEN, 32: datapath width; immediate and PC width. Supported values are 32 or 64.
- DEPTH, 2: decoded-entry buffer depth. Must be a power of two, ≥2.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_pc  out  XLEN  PC of head entry
- out_opcode / out_funct3 / out_funct7  out  7/3/7  decoded fields
- out_rs1 / out_rs2 / out_rd  out  5/5/5  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none (illegal)
- out_illegal  out  1  head is an illegal/unsupported encoding

## Operation
- Push on the clk edge with in_valid & in_ready. Pop on the edge with out_valid & out_ready.
- in_ready = (count != DEPTH), combinational from count only.
- out_valid = (count != 0). out_* are driven from storage[rd_ptr].
- Decode is combinational on in_instr and is written into storage at push.
- Decoded opcodes:
  - LUI, AUIPC → U
  - JAL → J
  - JALR, LOAD, OP-IMM, MISC-MEM, SYSTEM → I
  - BRANCH → B
  - STORE → S
  - OP → R
- Register fields not used by the format are forced to 0: rd for S/B, rs1 for U/J, rs2 for I/U/J.
- out_imm is 0 for R-type. Otherwise it is the standard RV immediate, sign-extended from instr[31] to XLEN.
- out_illegal = 1 for any of:
  - instr[1:0] != 2'b11
  - unlisted opcode
  - OP with funct7 ∉ {0000000, 0100000}
  - 0100000 with funct3 ∉ {000, 101}
  - OP-IMM shifts with a bad funct7
  - On illegal: out_fmt=7, fields/imm=0, pc still valid.
- Illegal entries still flow through the handshake. Squashing them is the consumer's job.

## Timing
- Latency: push at edge N gives out_valid=1 after edge N (1 cycle). Throughput is 1/cycle with out_ready held high.
- Full (count=DEPTH): in_ready=0, so no push occurs. A simultaneous pop frees the slot for the next cycle; no combinational ready passthrough.
- Empty: out_valid=0, so out_ready is ignored.
- Push and pop on the same edge: count unchanged, both pointers advance, wrapping modulo DEPTH.
- flush=1 at an edge: count and both pointers go to 0, any push/pop that edge is dropped, and out_valid=0 after the edge. flush has priority over push/pop.
- Reset (async, any time, including mid-stream): count, pointers and all storage go to 0. Resulting outputs:
  - out_valid=0
  - all out_* fields=0
  - in_ready=1
- Reset must not wait for clk.

## Configuration
- RV_M_EXT_EN defined: OP with funct7=0000001 (MUL/DIV/REM, all funct3) decodes as legal R-type.
- RV_M_EXT_EN undefined: those encodings set out_illegal=1.

## Structure
- Package riscv_pkg holds:
  - opcode localparams (OPC_LUI … OPC_SYSTEM)
  - the fmt_t encoding (FMT_R … FMT_NONE)
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV)
- Sub-module imm_gen (combinational: instr, fmt → imm[XLEN-1:0]) keeps immediate assembly out of the buffer logic.
- Top contains the format/illegal decoder, storage array, pointers and count.

## Test plan
- Push 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle:
  - opcode=0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0
  - fmt=0, imm=0, illegal=0
- Push 0xFFF00293 (addi x5,x0,-1) → fmt=1, rd=5, rs2=0, imm=0xFFFFFFFF. Push 0x0020A423 (sw x2,8(x1)) → fmt=2, rd=0, imm=8.
- Push 0xFE000EE3 (beq x0,x0,-4) → fmt=3, imm=0xFFFFFFFC, rd=0.
- Push 0x023100B3 (mul x1,x2,x3):
  - With RV_M_EXT_EN → illegal=0, fmt=0.
  - Without → illegal=1, fmt=7.
  - Push 0x00000000 → illegal=1.
- out_ready=0, push 3 back-to-back (DEPTH=2) → in_ready=0 after the 2nd push and the 3rd is held. Then out_ready=1 → entries emerge in order, with no loss or duplication.
- With 2 entries buffered, assert flush concurrently with in_valid → out_valid=0 next cycle and the offered word is discarded. Assert reset mid-stream → outputs 0 immediately, in_ready=1.
